// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the posted-write store buffer.
// Optional feature macro used by the design: STORE_BUFFER_COALESCE_EN.
package store_buffer_pkg;

    // Entry fields are held in parallel arrays in the top level so the data and
    // address widths can follow the Width parameter.
    typedef enum logic [1:0] {
        SelIdle,
        SelLoad,
        SelDrain
    } arb_sel_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Combinational youngest-first address search over the held buffer entries.
// Returns whether any valid entry matches the load address, and that entry's data.
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic [Width-1:0]             entry_addr [Depth],
    input  logic [Width-1:0]             entry_data [Depth],
    input  logic [Depth-1:0]             entry_valid,
    input  logic [ptr_width(Depth)-1:0]  tail,
    input  logic [Width-1:0]             ld_addr,
    output logic                         hit,
    output logic [Width-1:0]             hit_data
);

    localparam int unsigned PtrW = ptr_width(Depth);

    logic [PtrW-1:0] idx;

    // tail-1 is the youngest entry; the first match walking backwards wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < Depth; k++) begin
            idx = tail - PtrW'(k + 1);
            if (!hit && entry_valid[idx] && (entry_addr[idx] == ld_addr)) begin
                hit      = 1'b1;
                hit_data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of stores drained to memory when loads leave the port idle.
// Define STORE_BUFFER_COALESCE_EN to merge a store into the youngest entry on address match.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [Width-1:0]         st_addr,
    input  logic [Width-1:0]         st_wdata,
    input  logic                     ld_req,
    input  logic [Width-1:0]         ld_addr,
    output logic [Width-1:0]         ld_data,
    output logic                     ld_fwd,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [Width-1:0]         mem_addr,
    output logic [Width-1:0]         mem_wdata,
    input  logic [Width-1:0]         mem_rdata,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int unsigned PtrW = ptr_width(Depth);
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Width-1:0] addr_q [Depth];
    logic [Width-1:0] data_q [Depth];
    logic [Depth-1:0] valid_q;
    logic [PtrW-1:0]  head_q;
    logic [PtrW-1:0]  tail_q;
    logic [CntW-1:0]  count_q;

    arb_sel_e         sel;
    logic             drain;
    logic             full;
    logic [PtrW-1:0]  youngest;
    logic             coalesce_ok;
    logic             accept;
    logic             push;
    logic             coalesce_wr;
    logic             fwd_hit;
    logic [Width-1:0] fwd_data;

    // Loads always own the port; draining only happens on load-free cycles.
    always_comb begin
        sel = SelIdle;
        if (ld_req) begin
            sel = SelLoad;
        end else if (count_q != '0) begin
            sel = SelDrain;
        end
    end

    assign drain    = (sel == SelDrain);
    assign full     = (count_q == CntW'(Depth));
    assign youngest = tail_q - PtrW'(1);

`ifdef STORE_BUFFER_COALESCE_EN
    // The head leaving this cycle cannot absorb new data, so such a store allocates.
    assign coalesce_ok = (count_q != '0) && valid_q[youngest] &&
                         (addr_q[youngest] == st_addr) &&
                         !(drain && (head_q == youngest));
`else
    assign coalesce_ok = 1'b0;
`endif

    // Not bypassed by a same-cycle drain: a full buffer stalls for one cycle.
    assign st_ready    = !full || coalesce_ok;
    assign accept      = st_valid && st_ready;
    assign push        = accept && !coalesce_ok;
    assign coalesce_wr = accept && coalesce_ok;

    assign empty = (count_q == '0);
    assign count = count_q;

    sb_fwd_match #(
        .Width (Width),
        .Depth (Depth)
    ) u_fwd_match (
        .entry_addr  (addr_q),
        .entry_data  (data_q),
        .entry_valid (valid_q),
        .tail        (tail_q),
        .ld_addr     (ld_addr),
        .hit         (fwd_hit),
        .hit_data    (fwd_data)
    );

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ld_data   = '0;
        ld_fwd    = 1'b0;
        unique case (sel)
            SelLoad: begin
                mem_read = 1'b1;
                mem_addr = ld_addr;
                ld_fwd   = fwd_hit;
                ld_data  = fwd_hit ? fwd_data : mem_rdata;
            end
            SelDrain: begin
                mem_write = 1'b1;
                mem_addr  = addr_q[head_q];
                mem_wdata = data_q[head_q];
            end
            default: ;
        endcase
    end

    // push and drain never target the same slot: that would need count 0 and Depth at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_q[tail_q]  <= st_addr;
                data_q[tail_q]  <= st_wdata;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PtrW'(1);
            end
            if (coalesce_wr) begin
                data_q[youngest] <= st_wdata;
            end
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push) - CntW'(drain);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (Width=32, Depth=4).
// Expectations switch on STORE_BUFFER_COALESCE_EN to match the build.
module tb_store_buffer;

    localparam int unsigned Width = 32;
    localparam int unsigned Depth = 4;
    localparam logic [31:0] MemRd = 32'h1234_5678;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             st_valid;
    logic             st_ready;
    logic [Width-1:0] st_addr;
    logic [Width-1:0] st_wdata;
    logic             ld_req;
    logic [Width-1:0] ld_addr;
    logic [Width-1:0] ld_data;
    logic             ld_fwd;
    logic             mem_read;
    logic             mem_write;
    logic [Width-1:0] mem_addr;
    logic [Width-1:0] mem_wdata;
    logic [Width-1:0] mem_rdata;
    logic             empty;
    logic [2:0]       count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    store_buffer #(
        .Width (Width),
        .Depth (Depth)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_wdata  (st_wdata),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_fwd    (ld_fwd),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .empty     (empty),
        .count     (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_wdata = d;
        tick();
    endtask

    // One drain cycle: the head write must be on the port now, then it retires at the edge.
    task automatic check_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        settle();
        check({tag, "_wr"}, 32'(mem_write), 32'd1);
        check({tag, "_addr"}, mem_addr, a);
        check({tag, "_data"}, mem_wdata, d);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_wdata  = '0;
        ld_req    = 1'b0;
        ld_addr   = '0;
        mem_rdata = MemRd;
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_ld_fwd", 32'(ld_fwd), 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);

        // Single store, drained on the following idle cycle.
        st_valid = 1'b1;
        st_addr  = 32'h10;
        st_wdata = 32'hAAAA;
        settle();
        check("st1_no_write_yet", 32'(mem_write), 32'd0);
        tick();
        st_valid = 1'b0;
        settle();
        check("st1_count", 32'(count), 32'd1);
        check_write("st1", 32'h10, 32'hAAAA);
        settle();
        check("st1_count_after", 32'(count), 32'd0);
        check("st1_empty_after", 32'(empty), 32'd1);
        check("st1_idle_write", 32'(mem_write), 32'd0);

        // Fill under a held load; fifth store must stall.
        ld_req  = 1'b1;
        ld_addr = 32'h100;
        for (int i = 0; i < 4; i++) store(32'(4 * i), 32'h100 + 32'(i));
        st_valid = 1'b1;
        st_addr  = 32'h50;
        st_wdata = 32'h99;
        settle();
        check("full_count", 32'(count), 32'd4);
        check("full_st_ready", 32'(st_ready), 32'd0);
        check("full_mem_write", 32'(mem_write), 32'd0);
        check("full_mem_read", 32'(mem_read), 32'd1);
        check("full_mem_addr", mem_addr, 32'h100);
        check("full_ld_fwd", 32'(ld_fwd), 32'd0);
        check("full_ld_data", ld_data, MemRd);
        tick();
        st_valid = 1'b0;
        settle();
        check("stall_count", 32'(count), 32'd4);
        ld_req = 1'b0;
        check_write("fill0", 32'h0, 32'h100);
        check_write("fill1", 32'h4, 32'h101);
        check_write("fill2", 32'h8, 32'h102);
        check_write("fill3", 32'hC, 32'h103);
        settle();
        check("fill_drained_count", 32'(count), 32'd0);
        check("fill_no_extra_write", 32'(mem_write), 32'd0);

        // Forwarding from the youngest duplicate; same-cycle store is invisible.
        ld_req  = 1'b1;
        ld_addr = 32'h200;
        store(32'h20, 32'd1);
        store(32'h20, 32'd2);
        ld_addr  = 32'h20;
        st_wdata = 32'd3;
        settle();
        check("fwd_data", ld_data, 32'd2);
        check("fwd_flag", 32'(ld_fwd), 32'd1);
        check("fwd_mem_write", 32'(mem_write), 32'd0);
        check("fwd_mem_read", 32'(mem_read), 32'd1);
        tick();
        st_valid = 1'b0;
        ld_addr  = 32'h24;
        settle();
        check("miss_data", ld_data, MemRd);
        check("miss_flag", 32'(ld_fwd), 32'd0);
        ld_addr = 32'h20;
        settle();
        check("fwd_newest_data", ld_data, 32'd3);
`ifdef STORE_BUFFER_COALESCE_EN
        check("fwd_count", 32'(count), 32'd1);
        ld_req = 1'b0;
        check_write("dup0", 32'h20, 32'd3);
`else
        check("fwd_count", 32'(count), 32'd3);
        ld_req = 1'b0;
        check_write("dup0", 32'h20, 32'd1);
        check_write("dup1", 32'h20, 32'd2);
        check_write("dup2", 32'h20, 32'd3);
`endif
        settle();
        check("dup_done", 32'(mem_write), 32'd0);

        // Accept while draining keeps count steady; order preserved.
        ld_req  = 1'b1;
        ld_addr = 32'h200;
        store(32'h60, 32'd7);
        store(32'h64, 32'd8);
        ld_req   = 1'b0;
        st_valid = 1'b1;
        st_addr  = 32'h30;
        st_wdata = 32'd5;
        settle();
        check("acc_drain_count_before", 32'(count), 32'd2);
        check("acc_drain_wr", 32'(mem_write), 32'd1);
        check("acc_drain_addr", mem_addr, 32'h60);
        tick();
        st_valid = 1'b0;
        settle();
        check("acc_drain_count_after", 32'(count), 32'd2);
        check_write("ord1", 32'h64, 32'd8);
        check_write("ord2", 32'h30, 32'd5);
        settle();
        check("ord_count", 32'(count), 32'd0);

        // Reset mid-drain discards everything.
        ld_req  = 1'b1;
        ld_addr = 32'h200;
        store(32'h70, 32'h70);
        store(32'h74, 32'h74);
        store(32'h78, 32'h78);
        st_valid = 1'b0;
        ld_req   = 1'b0;
        settle();
        check("mid_count", 32'(count), 32'd3);
        check("mid_write", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_write", 32'(mem_write), 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_write", 32'(mem_write), 32'd0);
        end

        // Back-to-back stores to one address with the port held by loads.
        ld_req  = 1'b1;
        ld_addr = 32'h200;
        store(32'h40, 32'hA);
        store(32'h40, 32'hB);
        st_valid = 1'b0;
        settle();
`ifdef STORE_BUFFER_COALESCE_EN
        check("same_addr_count", 32'(count), 32'd1);
        ld_req = 1'b0;
        check_write("same0", 32'h40, 32'hB);
`else
        check("same_addr_count", 32'(count), 32'd2);
        ld_req = 1'b0;
        check_write("same0", 32'h40, 32'hA);
        check_write("same1", 32'h40, 32'hB);
`endif
        settle();
        check("same_done", 32'(mem_write), 32'd0);
        check("same_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
